imem_loader: RTL
================

# imem_loader

Boot-time program loader that sits between the host byte stream and the single-cycle MIPS core. It accepts a framed byte stream, assembles big-endian 32-bit instruction words, writes them into instruction memory, and holds the core frozen and in reset until a complete, valid image is resident. It drives the core's `enable` input, which gates register-file and memory writes. It is the producer of the instruction words the controller decodes.

## Interface
- `IMEM_AW`, default 8: instruction-memory word-address width. Capacity is 2^IMEM_AW words.
- `clk` input 1: single system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a load.
- `rx_valid` input 1: the host byte on `rx_data` is valid.
- `rx_data` input 8: host byte.
- `rx_ready` output 1: the loader accepts a byte this cycle.
- `imem_we` output 1: instruction-memory write strobe.
- `imem_addr` output IMEM_AW: word address for the write.
- `imem_wd` output 32: assembled instruction word.
- `enable` output 1: core run/freeze, wired to the controller `enable`.
- `cpu_reset` output 1: holds the core PC at 0.
- `busy` output 1: a load is in progress.
- `done` output 1: a valid image is loaded and the core is running.
- `err` output 1: the load was aborted.
- Decided: one clock; reset is asynchronous and active-low.

## Operation
- **Frame format:** LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4·N data bytes with the MSB first, then one checksum byte if enabled.
- **Byte acceptance:** a byte is accepted on a rising edge with `rx_valid & rx_ready`.
- **`rx_ready`:** 1 only in states LEN_HI, LEN_LO, DATA and CSUM; 0 in all other states.
- **States and transitions:**
  - IDLE –start→ LEN_HI.
  - LEN_HI → LEN_LO.
  - LEN_LO → DATA if N>0; → CSUM (or RUN with checksum disabled) if N=0; → ERROR if N > 2^IMEM_AW.
  - DATA → CSUM/RUN after the 4·N-th byte.
  - CSUM → RUN on a checksum match, → ERROR on a mismatch.
  - RUN –start→ LEN_HI.
  - ERROR –start→ LEN_HI.
- **Word assembly:** a 2-bit byte counter shifts bytes in. On the 4th byte, register `imem_wd`, set `imem_addr` to the word index (0..N-1, incremented after each write), and pulse `imem_we` for exactly one cycle.
- **Checksum:** 8-bit XOR of all data bytes. LEN bytes are excluded. For N=0 the expected checksum is 0x00.
- **`start` while busy:** ignored.
- **`start` in RUN:** `enable` drops and `cpu_reset` rises on the next edge. Memory is then rewritten from address 0.
- **Output values:**
  - `enable` = 1 and `cpu_reset` = 0 only in RUN.
  - `busy` = 1 in LEN_HI, LEN_LO, DATA and CSUM.
  - `done` = 1 in RUN.
  - `err` = 1 in ERROR.
- **Reset:**
  - State IDLE.
  - `enable`=0, `cpu_reset`=1, `imem_we`=0, `imem_addr`=0, `imem_wd`=0.
  - `busy`, `done` and `err` all 0.
  - Any in-flight load is discarded. Memory contents are not cleared.

## Timing
- All outputs are registered.
- `rx_ready` is a function of the registered state only; there is no combinational path from `rx_valid`.
- One byte per cycle maximum. Gaps in `rx_valid` stall the loader indefinitely; there is no timeout.
- `imem_we` is high in the cycle after the edge that accepted a word's 4th byte.
- The RUN transition is on the edge after the last `imem_we` pulse or after checksum acceptance, whichever is later. `enable` and `done` rise on that edge.
- `start` to `busy`=1: 1 edge.
- A minimal N=1 load with checksum takes 7 accepted bytes, and RUN is entered on the edge after the checksum byte.

## Configuration
- `IMEM_LOADER_CSUM_EN` defined: the CSUM state exists and the checksum byte is required; a mismatch enters ERROR.
- `IMEM_LOADER_CSUM_EN` undefined: no CSUM state and no checksum byte. RUN follows the last word directly (N=0: on the edge after LEN_LO is accepted). `err` is asserted only on a length overflow.

## Structure
- `imem_loader_pkg` holds:
  - the state enum `loader_state_t`;
  - `LEN_BYTES`=2 and `WORD_BYTES`=4;
  - the checksum width.
- Sub-module `word_assembler` holds the byte counter, shift register and XOR accumulator. It takes `clk`, `reset_n`, `clear`, `byte_en` and `byte_in`, and provides `word_out`, `word_valid` and `csum`.
- The top-level FSM, address counter and length compare live in `imem_loader`.

## Test plan
- Reset, then idle 10 cycles → `enable`=0, `cpu_reset`=1, `rx_ready`=0, all flags 0.
- `start`, bytes 00 02 | 20 08 00 05 | 00 00 00 0D | csum → `imem_we` pulses with addr 0 = 0x20080005, then addr 1 = 0x0000000D. `enable`=1 and `done`=1 on the edge after csum.
- Same frame with the checksum byte corrupted → `err`=1, `enable` stays 0. A second `start` with a correct frame → RUN.
- LEN = 0x0101 with IMEM_AW=8 → ERROR on the edge after LEN_LO is accepted, with no `imem_we` pulse.
- `rx_valid` toggled every other cycle during DATA, plus a `start` pulse mid-DATA → the `start` is ignored and words are correct. A `start` in RUN → `enable` drops on the next edge.
- Async `reset_n` low mid-DATA → all outputs return to reset values on the same edge, no further `imem_we` pulses, and state IDLE after release.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Optional checksum byte is enabled by defining IMEM_LOADER_CSUM_EN.
package imem_loader_pkg;

    // ST_FLUSH holds off RUN for the final write when no checksum byte follows the data.
    typedef logic [2:0] loader_state_t;

    localparam loader_state_t ST_IDLE   = 3'd0;
    localparam loader_state_t ST_LEN_HI = 3'd1;
    localparam loader_state_t ST_LEN_LO = 3'd2;
    localparam loader_state_t ST_DATA   = 3'd3;
    localparam loader_state_t ST_CSUM   = 3'd4;
    localparam loader_state_t ST_FLUSH  = 3'd5;
    localparam loader_state_t ST_RUN    = 3'd6;
    localparam loader_state_t ST_ERROR  = 3'd7;

    localparam int unsigned LEN_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CSUM_W     = 8;

    function automatic logic is_rx_state(input loader_state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

    function automatic logic is_busy_state(input loader_state_t s);
        return is_rx_state(s) || (s == ST_FLUSH);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream and instruction-memory write port of the loader.
// master: the loader; slave: host and instruction memory.
interface imem_loader_if #(
    parameter int unsigned IMEM_AW = 8
);
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               rx_ready;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wd;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wd
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wd
    );
endinterface

// File: rtl/word_assembler.sv
// Packs big-endian bytes into 32-bit words and keeps a running XOR checksum.
// word_valid is a one-cycle pulse in the cycle after the 4th byte is taken.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [31:0]       word_out,
    output logic              word_valid,
    output logic [CSUM_W-1:0] csum
);

    localparam int unsigned SHIFT_W = 8 * (WORD_BYTES - 1);

    logic [1:0]         cnt_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [31:0]        word_q;
    logic               valid_q;
    logic [CSUM_W-1:0]  csum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= 2'd0;
            shift_q <= '0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
            csum_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            if (clear) begin
                cnt_q   <= 2'd0;
                shift_q <= '0;
                csum_q  <= '0;
            end else if (byte_en) begin
                cnt_q  <= cnt_q + 2'd1;
                csum_q <= csum_q ^ byte_in;
                if (cnt_q == 2'(WORD_BYTES - 1)) begin
                    word_q  <= {shift_q, byte_in};
                    valid_q <= 1'b1;
                end else begin
                    shift_q <= {shift_q[SHIFT_W-9:0], byte_in};
                end
            end
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign csum       = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-framed byte stream, writes instruction memory and
// keeps the core frozen until the image is resident. Checksum byte: IMEM_LOADER_CSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned IMEM_AW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          enable,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [16:0] MAX_WORDS = 17'(2 ** IMEM_AW);

    loader_state_t      state_q, state_d;
    logic [7:0]         len_hi_q, len_hi_d;
    logic [17:0]        bytes_left_q, bytes_left_d;
    logic [IMEM_AW-1:0] addr_q, addr_d;

    logic rx_ready_q, busy_q, enable_q, cpu_reset_q, done_q, err_q;

    logic              accept;
    logic              clear;
    logic              byte_en;
    logic [15:0]       len;
    logic [31:0]       word_out;
    logic              word_valid;
    logic [CSUM_W-1:0] csum;

    assign accept  = bus.rx_valid & rx_ready_q;
    assign byte_en = accept & (state_q == ST_DATA);
    assign len     = {len_hi_q, bus.rx_data};

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .byte_en    (byte_en),
        .byte_in    (bus.rx_data),
        .word_out   (word_out),
        .word_valid (word_valid),
        .csum       (csum)
    );

    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        bytes_left_d = bytes_left_q;
        addr_d       = addr_q;
        clear        = 1'b0;

        if (word_valid) begin
            addr_d = addr_q + 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    addr_d  = '0;
                    clear   = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_hi_d = bus.rx_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    bytes_left_d = {len, 2'b00};
                    if ({1'b0, len} > MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else if (len == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_RUN;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    bytes_left_d = bytes_left_q - 18'd1;
                    if (bytes_left_q == 18'd1) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_FLUSH;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            ST_CSUM: begin
                // Earliest checksum accept is the edge that retires the last write.
                if (accept) begin
                    state_d = (bus.rx_data == csum) ? ST_RUN : ST_ERROR;
                end
            end
`else
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            len_hi_q     <= 8'd0;
            bytes_left_q <= 18'd0;
            addr_q       <= '0;
            rx_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            enable_q     <= 1'b0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            bytes_left_q <= bytes_left_d;
            addr_q       <= addr_d;
            rx_ready_q   <= is_rx_state(state_d);
            busy_q       <= is_busy_state(state_d);
            enable_q     <= (state_d == ST_RUN);
            cpu_reset_q  <= (state_d != ST_RUN);
            done_q       <= (state_d == ST_RUN);
            err_q        <= (state_d == ST_ERROR);
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.imem_we   = word_valid;
    assign bus.imem_addr = addr_q;
    assign bus.imem_wd   = word_out;
    assign enable        = enable_q;
    assign cpu_reset     = cpu_reset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule
